// File: rtl/pipeline_ctrl_pkg.sv
// Shared constants, state encoding and stall-vector encoder for the pipeline controller.
package pipeline_ctrl_pkg;

  localparam int unsigned REG_W       = 32;
  localparam int unsigned STALL_W     = 6;
  localparam int unsigned RUN_CNT_W   = 16;
  localparam int unsigned STALL_CNT_W = 32;
  localparam int unsigned FLUSH_CNT_W = 16;

  localparam logic             RST_ENABLE = 1'b1;
  localparam logic [REG_W-1:0] ZERO_WORD  = 32'h0000_0000;

  // Bit order: [0]pc [1]if [2]id [3]ex [4]mem [5]wb; wb is never held.
  localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
  localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
  localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;
  localparam logic [STALL_W-1:0] STALL_MEM  = 6'b011111;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  // Deepest requester wins: mem > ex > id.
  function automatic logic [STALL_W-1:0] stall_encode(input logic id, input logic ex,
                                                      input logic mem);
    logic [STALL_W-1:0] vec;
    vec = STALL_NONE;
    if (mem) begin
      vec = STALL_MEM;
    end else if (ex) begin
      vec = STALL_EX;
    end else if (id) begin
      vec = STALL_ID;
    end
    return vec;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module pipeline_ctrl_sat_counter
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] cnt
);

  logic [WIDTH-1:0] cnt_q;

  // Clear has priority over increment; no wrap past all-ones.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_q <= cnt_q + WIDTH'(1);
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: merges stall requests, sequences
// exception flushes with a redirect PC, and tracks stall statistics.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned MAX_STALL    = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_from_id,
  input  logic        stallreq_from_ex,
  input  logic        stallreq_from_mem,
  input  logic        flush_req,
  input  logic [31:0] flush_pc,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        stall_timeout,
  output logic [31:0] stall_cycles
);

  localparam int unsigned RUN_CMP_W = RUN_CNT_W + 1;
  localparam logic [FLUSH_CNT_W-1:0] FLUSH_RELOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [RUN_CMP_W-1:0]   STALL_LIMIT  = RUN_CMP_W'(MAX_STALL);

  state_e                 state_q;
  state_e                 state_d;
  state_e                 after_flush_c;
  logic [FLUSH_CNT_W-1:0] flush_cnt_q;
  logic [FLUSH_CNT_W-1:0] flush_cnt_d;
  logic [REG_W-1:0]       new_pc_q;
  logic [STALL_W-1:0]     req_vec_c;
  logic [STALL_W-1:0]     stall_c;
  logic                   flush_c;
  logic                   any_req_c;
  logic                   stall_any_c;
  logic [RUN_CNT_W-1:0]   run_cnt;
  logic                   timeout_q;

  assign req_vec_c     = stall_encode(stallreq_from_id, stallreq_from_ex, stallreq_from_mem);
  assign any_req_c     = stallreq_from_id | stallreq_from_ex | stallreq_from_mem;
  assign after_flush_c = any_req_c ? ST_STALL : ST_RUN;

  // State, flush countdown and latched redirect PC.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_q     <= ST_RUN;
      flush_cnt_q <= '0;
      new_pc_q    <= ZERO_WORD;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      if (flush_req) begin
        new_pc_q <= flush_pc;
      end
    end
  end

  // Next state and zero-latency stall/flush outputs; a flush request always wins.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    flush_c     = 1'b0;
    stall_c     = STALL_NONE;
    case (state_q)
      ST_RUN, ST_STALL: begin
        if (flush_req) begin
          flush_c     = 1'b1;
          flush_cnt_d = FLUSH_RELOAD;
          state_d     = (FLUSH_RELOAD == '0) ? after_flush_c : ST_FLUSH;
        end else if (any_req_c) begin
          stall_c = req_vec_c;
          state_d = ST_STALL;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FLUSH: begin
        flush_c = 1'b1;
        if (flush_req) begin
          flush_cnt_d = FLUSH_RELOAD;
          state_d     = (FLUSH_RELOAD == '0) ? after_flush_c : ST_FLUSH;
        end else if (flush_cnt_q <= FLUSH_CNT_W'(1)) begin
          flush_cnt_d = '0;
          state_d     = after_flush_c;
        end else begin
          flush_cnt_d = flush_cnt_q - FLUSH_CNT_W'(1);
        end
      end
      default: begin
        state_d     = ST_RUN;
        flush_cnt_d = '0;
      end
    endcase
    if (rst == RST_ENABLE) begin
      flush_c = 1'b0;
      stall_c = STALL_NONE;
    end
  end

  assign stall       = stall_c;
  assign flush       = flush_c;
  assign new_pc      = (rst == RST_ENABLE) ? ZERO_WORD : (flush_req ? flush_pc : new_pc_q);
  assign stall_any_c = |stall_c;

  // Consecutive stall-run length; any non-stall cycle (including flush) restarts it.
  pipeline_ctrl_sat_counter #(.WIDTH(RUN_CNT_W)) u_run_cnt (
    .clk (clk),
    .rst (rst),
    .inc (stall_any_c),
    .clr (~stall_any_c),
    .cnt (run_cnt)
  );

  // Lifetime count of stalled cycles.
  pipeline_ctrl_sat_counter #(.WIDTH(STALL_CNT_W)) u_stall_cycles (
    .clk (clk),
    .rst (rst),
    .inc (stall_any_c),
    .clr (1'b0),
    .cnt (stall_cycles)
  );

  // Sticky error flag once a stall run reaches the limit; does not break the stall.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      timeout_q <= 1'b0;
    end else if (stall_any_c && ((RUN_CMP_W'(run_cnt) + RUN_CMP_W'(1)) == STALL_LIMIT)) begin
      timeout_q <= 1'b1;
    end
  end

  assign stall_timeout = timeout_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl with FLUSH_CYCLES=2, MAX_STALL=4.
module tb_pipeline_ctrl;
  import pipeline_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stallreq_from_id = 1'b1;
  logic        stallreq_from_ex = 1'b1;
  logic        stallreq_from_mem = 1'b1;
  logic        flush_req = 1'b1;
  logic [31:0] flush_pc = 32'h0000_1234;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        stall_timeout;
  logic [31:0] stall_cycles;

  int checks = 0;
  int failures = 0;

  pipeline_ctrl #(.FLUSH_CYCLES(2), .MAX_STALL(4)) dut (
    .clk               (clk),
    .rst               (rst),
    .stallreq_from_id  (stallreq_from_id),
    .stallreq_from_ex  (stallreq_from_ex),
    .stallreq_from_mem (stallreq_from_mem),
    .flush_req         (flush_req),
    .flush_pc          (flush_pc),
    .stall             (stall),
    .flush             (flush),
    .new_pc            (new_pc),
    .stall_timeout     (stall_timeout),
    .stall_cycles      (stall_cycles)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input logic id, input logic ex, input logic mem);
    stallreq_from_id  = id;
    stallreq_from_ex  = ex;
    stallreq_from_mem = mem;
  endtask

  // Drive at negedge, sample combinational/registered outputs 1ns later.
  initial begin
    // 1: reset with every request high
    @(negedge clk); #1;
    chk("rst_stall_comb", 32'(stall), 32'(6'b000000));
    chk("rst_flush_comb", 32'(flush), 32'd0);
    @(negedge clk);
    @(negedge clk); #1;
    chk("rst_stall", 32'(stall), 32'(6'b000000));
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_new_pc", new_pc, 32'h0);
    chk("rst_stall_cycles", stall_cycles, 32'd0);
    chk("rst_timeout", 32'(stall_timeout), 32'd0);
    chk("rst_state", 32'(dut.state_q), 32'(ST_RUN));

    // 2: id stall x3 then ex+mem together
    @(negedge clk);
    rst = 1'b0; flush_req = 1'b0; set_req(1'b1, 1'b0, 1'b0); #1;
    chk("id_stall_1", 32'(stall), 32'(6'b000111));
    @(negedge clk); #1;
    chk("id_stall_2", 32'(stall), 32'(6'b000111));
    @(negedge clk); #1;
    chk("id_stall_3", 32'(stall), 32'(6'b000111));
    chk("id_state", 32'(dut.state_q), 32'(ST_STALL));
    @(negedge clk);
    set_req(1'b0, 1'b1, 1'b1); #1;
    chk("exmem_stall", 32'(stall), 32'(6'b011111));
    @(negedge clk);
    set_req(1'b0, 1'b0, 1'b0); #1;
    chk("drop_stall", 32'(stall), 32'(6'b000000));
    chk("drop_cycles", stall_cycles, 32'd4);
    chk("run4_timeout", 32'(stall_timeout), 32'd1);
    @(negedge clk); #1;
    chk("drop_state", 32'(dut.state_q), 32'(ST_RUN));
    chk("drop_cycles_hold", stall_cycles, 32'd4);

    // 3: flush with ex request held
    @(negedge clk);
    flush_req = 1'b1; flush_pc = 32'h0000_0020; set_req(1'b0, 1'b1, 1'b0); #1;
    chk("fl1_flush", 32'(flush), 32'd1);
    chk("fl1_stall", 32'(stall), 32'(6'b000000));
    chk("fl1_new_pc", new_pc, 32'h20);
    @(negedge clk);
    flush_req = 1'b0; flush_pc = 32'hDEAD_BEEF; #1;
    chk("fl2_flush", 32'(flush), 32'd1);
    chk("fl2_stall", 32'(stall), 32'(6'b000000));
    chk("fl2_new_pc", new_pc, 32'h20);
    chk("fl2_state", 32'(dut.state_q), 32'(ST_FLUSH));
    @(negedge clk); #1;
    chk("fl3_flush", 32'(flush), 32'd0);
    chk("fl3_stall", 32'(stall), 32'(6'b001111));
    chk("fl3_new_pc_hold", new_pc, 32'h20);
    chk("fl3_state", 32'(dut.state_q), 32'(ST_STALL));
    chk("fl3_cycles", stall_cycles, 32'd4);

    // 4: flush restarted on its second cycle
    @(negedge clk);
    flush_req = 1'b1; flush_pc = 32'h0000_0030; #1;
    chk("rf1_flush", 32'(flush), 32'd1);
    chk("rf1_new_pc", new_pc, 32'h30);
    chk("rf1_cycles", stall_cycles, 32'd5);
    @(negedge clk);
    flush_pc = 32'h0000_0040; #1;
    chk("rf2_flush", 32'(flush), 32'd1);
    chk("rf2_stall", 32'(stall), 32'(6'b000000));
    chk("rf2_new_pc", new_pc, 32'h40);
    @(negedge clk);
    flush_req = 1'b0; flush_pc = 32'h0; #1;
    chk("rf3_flush", 32'(flush), 32'd1);
    chk("rf3_new_pc", new_pc, 32'h40);
    chk("rf3_state", 32'(dut.state_q), 32'(ST_FLUSH));
    @(negedge clk); #1;
    chk("rf4_flush", 32'(flush), 32'd0);
    chk("rf4_stall", 32'(stall), 32'(6'b001111));
    chk("rf4_new_pc", new_pc, 32'h40);
    chk("rf4_cycles", stall_cycles, 32'd5);
    @(negedge clk);
    set_req(1'b0, 1'b0, 1'b0); #1;
    chk("rf5_stall", 32'(stall), 32'(6'b000000));
    chk("rf5_cycles", stall_cycles, 32'd6);

    // 5: stall timeout at MAX_STALL=4
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; #1;
    chk("to_rst_flag", 32'(stall_timeout), 32'd0);
    chk("to_rst_cycles", stall_cycles, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      set_req(1'b0, 1'b0, 1'b1); #1;
      chk("to_stall", 32'(stall), 32'(6'b011111));
      chk("to_flag_low", 32'(stall_timeout), 32'd0);
    end
    @(negedge clk); #1;
    chk("to_flag_set", 32'(stall_timeout), 32'd1);
    chk("to_stall_kept", 32'(stall), 32'(6'b011111));
    @(negedge clk);
    set_req(1'b0, 1'b0, 1'b0); #1;
    chk("to_flag_sticky", 32'(stall_timeout), 32'd1);
    chk("to_drop_stall", 32'(stall), 32'(6'b000000));
    @(negedge clk); #1;
    chk("to_flag_sticky2", 32'(stall_timeout), 32'd1);

    // 6: saturation of stall_cycles, then reset mid-stall and mid-flush
    @(negedge clk);
    set_req(1'b0, 1'b0, 1'b1);
    force dut.u_stall_cycles.cnt_q = 32'hFFFF_FFFE;
    @(negedge clk);
    release dut.u_stall_cycles.cnt_q;
    @(negedge clk);
    @(negedge clk); #1;
    chk("sat_max", stall_cycles, 32'hFFFF_FFFF);
    @(negedge clk); #1;
    chk("sat_hold", stall_cycles, 32'hFFFF_FFFF);
    chk("sat_stall", 32'(stall), 32'(6'b011111));
    @(negedge clk);
    rst = 1'b1; #1;
    chk("rst_mid_stall_comb", 32'(stall), 32'(6'b000000));
    @(negedge clk); #1;
    chk("rstm_cycles", stall_cycles, 32'd0);
    chk("rstm_timeout", 32'(stall_timeout), 32'd0);
    chk("rstm_flush", 32'(flush), 32'd0);
    chk("rstm_new_pc", new_pc, 32'h0);
    chk("rstm_state", 32'(dut.state_q), 32'(ST_RUN));
    @(negedge clk);
    rst = 1'b0; #1;
    chk("post_rst_stall", 32'(stall), 32'(6'b011111));
    @(negedge clk);
    set_req(1'b0, 1'b0, 1'b0); flush_req = 1'b1; flush_pc = 32'h0000_0080; #1;
    chk("rf_flush", 32'(flush), 32'd1);
    chk("rf_new_pc", new_pc, 32'h80);
    @(negedge clk);
    flush_req = 1'b0; rst = 1'b1; #1;
    chk("rf_rst_flush_comb", 32'(flush), 32'd0);
    @(negedge clk);
    rst = 1'b0; #1;
    chk("rf_abort_flush", 32'(flush), 32'd0);
    chk("rf_abort_state", 32'(dut.state_q), 32'(ST_RUN));
    chk("rf_abort_new_pc", new_pc, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
